gf16_mul_issue_ctrl: RTL

//  Issue/collect wrapper around the 16-bit GF(2^m) systolic multiplier array.

---
 rtl/gf16_mul_issue_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/gf16_mul_issue_ctrl.sv
// rtl/gf16_mul_issue_ctrl.sv - issue/collect wrapper for the GF(2^16) systolic multiplier array
module gf16_mul_issue_ctrl #(
  parameter int LATENCY    = 12,
  parameter int FIFO_DEPTH = 16,
  parameter int TAG_W      = 4,
  parameter int ISSUE_GAP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic [15:0]      in_g,
  input  logic [TAG_W-1:0] in_tag,
  output logic             ctr,
  output logic [16:1]      ai,
  output logic [16:1]      bi,
  output logic [16:1]      gi,
  input  logic [1:16]      po,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_p,
  output logic [TAG_W-1:0] out_tag
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = $clog2(LATENCY + FIFO_DEPTH + 1);
  localparam int GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(ISSUE_GAP - 1);

  logic             hold_full_q;
  logic [15:0]      hold_a_q, hold_b_q, hold_g_q;
  logic [TAG_W-1:0] hold_tag_q;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [LATENCY-1:0] vld_q;
  logic [TAG_W-1:0] tag_pipe_q [LATENCY];
  logic [15:0]      mem_p_q   [FIFO_DEPTH];
  logic [TAG_W-1:0] mem_tag_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OCC_W-1:0] occ;
  logic             credits_ok, issue_now, fifo_push, fifo_pop;

  // Credits cover every product that still needs a FIFO slot: in the pipe or already stored.
  always_comb begin
    occ = OCC_W'(cnt_q);
    for (int i = 0; i < LATENCY; i++) begin
      occ = occ + OCC_W'(vld_q[i]);
    end
    credits_ok = occ < OCC_W'(FIFO_DEPTH);
  end

  assign issue_now = !rst && hold_full_q && credits_ok && (gap_q == '0);
  assign in_ready  = !rst && (!hold_full_q || issue_now);
  assign ctr       = issue_now;
  // Operand bit i of the 16-bit inputs lands on array lane i+1.
  assign ai        = issue_now ? hold_a_q : '0;
  assign bi        = issue_now ? hold_b_q : '0;
  assign gi        = issue_now ? hold_g_q : '0;

  assign fifo_push = vld_q[LATENCY-1];
  assign out_valid = (cnt_q != '0);
  assign fifo_pop  = out_valid && out_ready;
  assign out_p     = out_valid ? mem_p_q[rd_ptr_q] : '0;
  assign out_tag   = out_valid ? mem_tag_q[rd_ptr_q] : '0;

  // Next-state for gap counter, FIFO pointers and occupancy.
  always_comb begin
    gap_d = gap_q;
    if (issue_now) begin
      gap_d = GAP_LOAD;
    end else if (gap_q != '0) begin
      gap_d = gap_q - GAP_W'(1);
    end
    wr_ptr_d = wr_ptr_q;
    if (fifo_push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    rd_ptr_d = rd_ptr_q;
    if (fifo_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    cnt_d = cnt_q;
    if (fifo_push && !fifo_pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!fifo_push && fifo_pop) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // One-entry holding register: refills in the same cycle it issues.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      hold_full_q <= 1'b1;
      hold_a_q    <= in_a;
      hold_b_q    <= in_b;
      hold_g_q    <= in_g;
      hold_tag_q  <= in_tag;
    end else if (issue_now) begin
      hold_full_q <= 1'b0;
    end
  end

  // Issue spacing counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end

  // Valid/tag pipe mirroring the array latency; clearing it drops in-flight products.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= issue_now;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
    tag_pipe_q[0] <= hold_tag_q;
    for (int i = 1; i < LATENCY; i++) begin
      tag_pipe_q[i] <= tag_pipe_q[i-1];
    end
  end

  // Result FIFO pointers and count; credits keep a push from ever meeting a full FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      assert (!(fifo_push && cnt_q == CNT_FULL));
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Result storage; po[1] (x^15) becomes bit 15 of the stored product.
  always_ff @(posedge clk) begin
    if (!rst && fifo_push) begin
      mem_p_q[wr_ptr_q]   <= po;
      mem_tag_q[wr_ptr_q] <= tag_pipe_q[LATENCY-1];
    end
  end

endmodule
